// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common-data-bus arbiter: the broadcast packet seen by
// every consumer of a completing result.
package cdb_arbiter_pkg;

   localparam int PADDR_W   = 7;
   localparam int ROB_IDX_W = 5;

   typedef struct packed {
      logic                 cdb_broadcast;
      logic [PADDR_W-1:0]   cdb_p_addr;
      logic [4:0]           cdb_aaddr;
      logic [31:0]          cdb_rd;
      logic [ROB_IDX_W-1:0] cdb_rob_idx;
   } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter.sv
// Two-lane common-data-bus arbiter: each functional unit parks one completion in
// a hold register, and up to two held entries are broadcast per cycle in round-robin order.
module cdb_arbiter #(
   parameter int  NUM_FU    = 5,
   parameter int  PADDR_W   = cdb_arbiter_pkg::PADDR_W,
   parameter int  ROB_IDX_W = cdb_arbiter_pkg::ROB_IDX_W,
   localparam int PTR_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush,
   input  logic [NUM_FU-1:0]                    fu_valid,
   output logic [NUM_FU-1:0]                    fu_ready,
   input  logic [NUM_FU-1:0][PADDR_W-1:0]       fu_p_addr,
   input  logic [NUM_FU-1:0][4:0]               fu_aaddr,
   input  logic [NUM_FU-1:0][31:0]              fu_rd,
   input  logic [NUM_FU-1:0][ROB_IDX_W-1:0]     fu_rob_idx,
   output cdb_arbiter_pkg::cdb_pkt_t            cdb_pkt,
   output cdb_arbiter_pkg::cdb_pkt_t            cdb_pkt2,
   output logic [PTR_W-1:0]                     dbg_rr_ptr
);

   // Handshake: port i transfers on a rising edge where fu_valid[i] && fu_ready[i];
   // the FU must hold its payload stable while fu_valid[i]=1 and fu_ready[i]=0.

   logic [NUM_FU-1:0]                hold_valid;
   logic [NUM_FU-1:0][PADDR_W-1:0]   hold_p_addr;
   logic [NUM_FU-1:0][4:0]           hold_aaddr;
   logic [NUM_FU-1:0][31:0]          hold_rd;
   logic [NUM_FU-1:0][ROB_IDX_W-1:0] hold_rob_idx;

   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  cand;
   logic [PTR_W-1:0]  g0_idx;
   logic [PTR_W-1:0]  g1_idx;
   logic              g0_found;
   logic              g1_found;
   logic [NUM_FU-1:0] grant;
   logic [NUM_FU-1:0] accept;

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_FU) s = s - NUM_FU;
      return PTR_W'(s);
   endfunction

   // Scan from rr_ptr; the first valid entry takes lane 0, the second lane 1.
   always_comb begin
      cand     = '0;
      g0_idx   = '0;
      g1_idx   = '0;
      g0_found = 1'b0;
      g1_found = 1'b0;
      for (int k = 0; k < NUM_FU; k++) begin
         cand = wrap_add(rr_ptr, k);
         if (hold_valid[cand]) begin
            if (!g0_found) begin
               g0_found = 1'b1;
               g0_idx   = cand;
            end else if (!g1_found) begin
               g1_found = 1'b1;
               g1_idx   = cand;
            end
         end
      end
   end

   always_comb begin
      grant = '0;
      if (g0_found) grant[g0_idx] = 1'b1;
      if (g1_found) grant[g1_idx] = 1'b1;
   end

   assign fu_ready   = (~hold_valid | grant) & {NUM_FU{~flush & ~rst}};
   assign accept     = fu_valid & fu_ready;
   assign dbg_rr_ptr = rr_ptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         hold_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i])     hold_valid[i] <= 1'b1;
            else if (grant[i]) hold_valid[i] <= 1'b0;
         end
      end
   end

   // Payload needs no reset: it is only observed behind hold_valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (accept[i]) begin
            hold_p_addr[i]  <= fu_p_addr[i];
            hold_aaddr[i]   <= fu_aaddr[i];
            hold_rd[i]      <= fu_rd[i];
            hold_rob_idx[i] <= fu_rob_idx[i];
         end
      end
   end

   // Idle lanes keep their last payload; only the broadcast bit drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_pkt  <= '0;
         cdb_pkt2 <= '0;
         rr_ptr   <= '0;
      end else if (flush) begin
         cdb_pkt.cdb_broadcast  <= 1'b0;
         cdb_pkt2.cdb_broadcast <= 1'b0;
      end else begin
         cdb_pkt.cdb_broadcast  <= g0_found;
         cdb_pkt2.cdb_broadcast <= g1_found;
         if (g0_found) begin
            cdb_pkt.cdb_p_addr  <= hold_p_addr[g0_idx];
            cdb_pkt.cdb_aaddr   <= hold_aaddr[g0_idx];
            cdb_pkt.cdb_rd      <= hold_rd[g0_idx];
            cdb_pkt.cdb_rob_idx <= hold_rob_idx[g0_idx];
         end
         if (g1_found) begin
            cdb_pkt2.cdb_p_addr  <= hold_p_addr[g1_idx];
            cdb_pkt2.cdb_aaddr   <= hold_aaddr[g1_idx];
            cdb_pkt2.cdb_rd      <= hold_rd[g1_idx];
            cdb_pkt2.cdb_rob_idx <= hold_rob_idx[g1_idx];
         end
         if (g1_found)      rr_ptr <= wrap_add(g1_idx, 1);
         else if (g0_found) rr_ptr <= wrap_add(g0_idx, 1);
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single completion, full contention,
// wrap-around, flush, streaming and mid-stream reset.
module tb_cdb_arbiter;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      flush;
   logic [4:0]                fu_valid;
   logic [4:0]                fu_ready;
   logic [4:0][6:0]           fu_p_addr;
   logic [4:0][4:0]           fu_aaddr;
   logic [4:0][31:0]          fu_rd;
   logic [4:0][4:0]           fu_rob_idx;
   cdb_arbiter_pkg::cdb_pkt_t cdb_pkt;
   cdb_arbiter_pkg::cdb_pkt_t cdb_pkt2;
   logic [2:0]                dbg_rr_ptr;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];

   localparam int N_STREAM = 8;

   cdb_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .fu_valid   (fu_valid),
      .fu_ready   (fu_ready),
      .fu_p_addr  (fu_p_addr),
      .fu_aaddr   (fu_aaddr),
      .fu_rd      (fu_rd),
      .fu_rob_idx (fu_rob_idx),
      .cdb_pkt    (cdb_pkt),
      .cdb_pkt2   (cdb_pkt2),
      .dbg_rr_ptr (dbg_rr_ptr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_lane(input string tag, input cdb_arbiter_pkg::cdb_pkt_t pkt,
                           input logic [6:0] p, input logic [4:0] a,
                           input logic [31:0] d, input logic [4:0] r);
      chk({tag, "_bc"},   pkt.cdb_broadcast, 1'b1);
      chk({tag, "_p"},    pkt.cdb_p_addr,    p);
      chk({tag, "_a"},    pkt.cdb_aaddr,     a);
      chk({tag, "_rd"},   pkt.cdb_rd,        d);
      chk({tag, "_rob"},  pkt.cdb_rob_idx,   r);
   endtask

   // Advance one cycle and sample 1 time unit after the edge; both-lane cycles
   // also check that the two destination registers differ.
   task automatic step();
      @(posedge clk);
      #1;
      if (cdb_pkt.cdb_broadcast === 1'b1 && cdb_pkt2.cdb_broadcast === 1'b1)
         chk("lane_p_addr_distinct", 64'(cdb_pkt.cdb_p_addr != cdb_pkt2.cdb_p_addr), 64'd1);
   endtask

   task automatic drive(input int i, input logic [6:0] p, input logic [4:0] a,
                        input logic [31:0] d, input logic [4:0] r);
      fu_valid[i]   = 1'b1;
      fu_p_addr[i]  = p;
      fu_aaddr[i]   = a;
      fu_rd[i]      = d;
      fu_rob_idx[i] = r;
   endtask

   // Drop valids and scramble payloads so held entries must not track the inputs.
   task automatic idle();
      fu_valid   = '0;
      fu_p_addr  = '1;
      fu_aaddr   = '1;
      fu_rd      = '1;
      fu_rob_idx = '1;
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      idle();
      step();
      step();
      chk("rst_ready", fu_ready, 5'h00);
      chk("rst_pkt",   cdb_pkt,  '0);
      chk("rst_pkt2",  cdb_pkt2, '0);
      chk("rst_rr",    dbg_rr_ptr, 3'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", fu_ready, 5'h1f);

      // All five FUs complete together with rr_ptr=0.
      for (int i = 0; i < 5; i++) drive(i, 7'(10 + i), 5'(i + 1), 32'h1000_0000 + i, 5'(i));
      step();
      idle();
      #1;
      chk("all5_ready_a1", fu_ready, 5'b00011);
      chk("all5_bc0_a1",   cdb_pkt.cdb_broadcast,  1'b0);
      chk("all5_bc1_a1",   cdb_pkt2.cdb_broadcast, 1'b0);
      step();
      chk_lane("all5_l0_fu0", cdb_pkt,  7'd10, 5'd1, 32'h1000_0000, 5'd0);
      chk_lane("all5_l1_fu1", cdb_pkt2, 7'd11, 5'd2, 32'h1000_0001, 5'd1);
      chk("all5_rr_2",     dbg_rr_ptr, 3'd2);
      chk("all5_ready_a2", fu_ready, 5'b01111);
      step();
      chk_lane("all5_l0_fu2", cdb_pkt,  7'd12, 5'd3, 32'h1000_0002, 5'd2);
      chk_lane("all5_l1_fu3", cdb_pkt2, 7'd13, 5'd4, 32'h1000_0003, 5'd3);
      chk("all5_rr_4",     dbg_rr_ptr, 3'd4);
      chk("all5_ready_a3", fu_ready, 5'h1f);
      step();
      chk_lane("all5_l0_fu4", cdb_pkt, 7'd14, 5'd5, 32'h1000_0004, 5'd4);
      chk("all5_l1_idle",  cdb_pkt2.cdb_broadcast, 1'b0);
      chk("all5_rr_0",     dbg_rr_ptr, 3'd0);
      step();
      chk("all5_drain_bc0", cdb_pkt.cdb_broadcast,  1'b0);
      chk("all5_drain_bc1", cdb_pkt2.cdb_broadcast, 1'b0);

      // Single uncontended ALU completion with aaddr=0.
      drive(0, 7'd5, 5'd0, 32'hDEAD_BEEF, 5'd3);
      step();
      idle();
      chk("single_c2_bc0", cdb_pkt.cdb_broadcast, 1'b0);
      step();
      chk_lane("single_c3", cdb_pkt, 7'd5, 5'd0, 32'hDEAD_BEEF, 5'd3);
      chk("single_c3_bc1", cdb_pkt2.cdb_broadcast, 1'b0);
      chk("single_rr_1",   dbg_rr_ptr, 3'd1);
      step();
      chk("single_c4_bc0", cdb_pkt.cdb_broadcast, 1'b0);

      // Wrap-around: move rr_ptr to 4, then hold FU4 and FU0.
      drive(3, 7'd20, 5'd7, 32'h33, 5'd1);
      step();
      idle();
      step();
      chk_lane("wrap_prep_fu3", cdb_pkt, 7'd20, 5'd7, 32'h33, 5'd1);
      chk("wrap_prep_rr_4", dbg_rr_ptr, 3'd4);
      drive(4, 7'd30, 5'd8, 32'h44, 5'd2);
      drive(0, 7'd31, 5'd9, 32'h55, 5'd6);
      step();
      idle();
      step();
      chk_lane("wrap_l0_fu4", cdb_pkt,  7'd30, 5'd8, 32'h44, 5'd2);
      chk_lane("wrap_l1_fu0", cdb_pkt2, 7'd31, 5'd9, 32'h55, 5'd6);
      chk("wrap_rr_1", dbg_rr_ptr, 3'd1);

      // Flush with three entries held.
      drive(1, 7'd40, 5'd1, 32'hA1, 5'd10);
      drive(2, 7'd41, 5'd2, 32'hA2, 5'd11);
      drive(3, 7'd42, 5'd3, 32'hA3, 5'd12);
      step();
      idle();
      flush = 1'b1;
      #1;
      chk("flush_ready_low", fu_ready, 5'h00);
      step();
      flush = 1'b0;
      #1;
      chk("flush_bc0",      cdb_pkt.cdb_broadcast,  1'b0);
      chk("flush_bc1",      cdb_pkt2.cdb_broadcast, 1'b0);
      chk("flush_rr_kept",  dbg_rr_ptr, 3'd1);
      chk("flush_ready_up", fu_ready, 5'h1f);
      step();
      chk("flush_late_bc0", cdb_pkt.cdb_broadcast,  1'b0);
      chk("flush_late_bc1", cdb_pkt2.cdb_broadcast, 1'b0);

      // Back-to-back MUL stream: one broadcast per cycle, in order.
      for (int c = 0; c < N_STREAM + 2; c++) begin
         if (c < N_STREAM) begin
            drive(1, 7'(60 + c), 5'd1, 32'(c + 1), 5'(c));
            exp_q.push_back(32'(c + 1));
            #1;
            chk("stream_ready", fu_ready[1], 1'b1);
         end else begin
            idle();
         end
         step();
         if (c >= 1 && c <= N_STREAM) begin
            chk("stream_bc", cdb_pkt.cdb_broadcast, 1'b1);
            chk("stream_rd", cdb_pkt.cdb_rd, exp_q.pop_front());
         end else begin
            chk("stream_gap_bc", cdb_pkt.cdb_broadcast, 1'b0);
         end
         chk("stream_bc1", cdb_pkt2.cdb_broadcast, 1'b0);
      end
      chk("stream_q_empty", exp_q.size(), 0);
      chk("stream_rr_2",    dbg_rr_ptr, 3'd2);

      // Reset mid-stream with four entries held.
      for (int i = 0; i < 4; i++) drive(i, 7'(70 + i), 5'(i), 32'hB0 + i, 5'(i));
      step();
      idle();
      rst = 1'b1;
      #1;
      chk("midrst_ready", fu_ready, 5'h00);
      step();
      chk("midrst_pkt",   cdb_pkt,  '0);
      chk("midrst_pkt2",  cdb_pkt2, '0);
      chk("midrst_rr",    dbg_rr_ptr, 3'd0);
      chk("midrst_ready2", fu_ready, 5'h00);
      step();
      rst = 1'b0;
      #1;
      chk("midrst_release_ready", fu_ready, 5'h1f);
      for (int c = 0; c < 4; c++) begin
         step();
         chk("midrst_no_bc0", cdb_pkt.cdb_broadcast,  1'b0);
         chk("midrst_no_bc1", cdb_pkt2.cdb_broadcast, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
- REQ-001: Parameter NUM_FU, default 5, is the number of functional-unit completion ports: 0=alu, 1=mul, 2=div, 3=br, 4=ld.
- REQ-002: Parameter PADDR_W, default 7, is the physical register address width (96-entry PRF).
- REQ-003: Parameter ROB_IDX_W, default 5, is the ROB index width.
- REQ-004: clk  input  1  is the single clock; all state updates on the rising edge.
- REQ-005: rst  input  1  is a synchronous, active-high reset.
- REQ-006: flush  input  1  is a mispredict flush that discards all held completions.
- REQ-007: fu_valid  input  NUM_FU  is the per-FU completion valid.
- REQ-008: fu_ready  output  NUM_FU  is the per-FU acceptance; a transfer occurs when fu_valid[i] && fu_ready[i].
- REQ-009: fu_p_addr  input  NUM_FU x PADDR_W  is the destination physical register per FU.
- REQ-010: fu_aaddr  input  NUM_FU x 5  is the destination architectural register per FU.
- REQ-011: fu_rd  input  NUM_FU x 32  is the result data per FU.
- REQ-012: fu_rob_idx  input  NUM_FU x ROB_IDX_W  is the ROB index per FU.
- REQ-013: cdb_pkt  output  cdb_pkt_t  is broadcast lane 0, with fields cdb_broadcast, cdb_p_addr, cdb_aaddr, cdb_rd, cdb_rob_idx.
- REQ-014: cdb_pkt2  output  cdb_pkt_t  is broadcast lane 1, with the same fields as lane 0.

Function
- REQ-015: Each FU port SHALL own a 1-entry hold register (valid bit plus payload).
- REQ-016: fu_ready[i] SHALL equal (!hold_valid[i] || grant[i]) && !flush, computed combinationally.
- REQ-017: A transfer on port i SHALL load the hold register on the next edge; a grant without a new transfer SHALL clear it.
- REQ-018: Each cycle, up to 2 valid hold entries SHALL be granted in round-robin order starting at rr_ptr.
  - The first granted index SHALL go to lane 0 and the second to lane 1.
- REQ-019: The CDB outputs SHALL be registered: a grant in cycle N appears on cdb_pkt/cdb_pkt2 in cycle N+1, with cdb_broadcast=1 and the held payload.
- REQ-020: A lane with no grant SHALL drive cdb_broadcast=0 in the next cycle; its payload fields are don't-care but SHALL hold their previous value.
- REQ-021: rr_ptr SHALL advance to (last granted index + 1) mod NUM_FU; it SHALL hold when nothing is granted.
- REQ-022: The wrap rule SHALL hold at the boundary: with 2 grants ending at index NUM_FU-1, rr_ptr SHALL become 0.
- REQ-023: Latency from an FU handshake to broadcast SHALL be at least 2 cycles (hold, then output register) and exactly 2 cycles when uncontended.
- REQ-024: Two lanes SHALL never carry the same FU entry in the same cycle.
- REQ-025: When both lanes broadcast, their cdb_p_addr values SHALL differ (guaranteed by the rename stage; the bench asserts it).
- REQ-026: Completions with aaddr=0 SHALL be broadcast normally; suppressing the write to register 0 is the consumer's job.
- REQ-027: On flush=1, the next edge SHALL clear every hold_valid and both cdb_broadcast bits; no transfers are accepted in that cycle.
  - rr_ptr SHALL be preserved.
- REQ-028: Back-pressure: an ungranted hold entry SHALL retain its payload unchanged, and fu_ready stays 0 until it is granted.

Reset
- REQ-029: While rst=1, all hold_valid bits, cdb_pkt, cdb_pkt2 (all fields) and rr_ptr SHALL reset to 0 on the next edge.
- REQ-030: fu_ready SHALL read 0 during rst and 1 on all ports in the first cycle after reset release.
- REQ-031: Reset asserted mid-operation SHALL drop all pending completions; none of them is broadcast after release.

Verification
- REQ-032: Single completion: alu valid, p_addr=5, rd=0xDEADBEEF at cycle 1 -> cdb_pkt.cdb_broadcast=1, p_addr=5, rd=0xDEADBEEF at cycle 3; cdb_pkt2.cdb_broadcast=0.
- REQ-033: All 5 FUs valid in one cycle with rr_ptr=0:
  - FUs 0,1 broadcast first, then 2,3, then 4.
  - rr_ptr steps 2 -> 4 -> 0.
  - fu_ready[4] stays 0 until its grant.
- REQ-034: Wrap-around: rr_ptr=4 with FUs 4 and 0 held -> lane0=FU4, lane1=FU0 next cycle; rr_ptr becomes 1.
- REQ-035: Flush with 3 entries held -> no broadcast in the following cycle; all fu_ready=1 one cycle later; rr_ptr unchanged.
- REQ-036: Back-to-back streaming: mul valid every cycle with data 1, 2, 3, ..., no contention -> one broadcast per cycle, in order, no bubbles.
- REQ-037: Reset mid-stream: rst pulsed while 4 entries are held -> zero broadcasts after release; all outputs read 0 during rst.
